// File: rtl/stochastic_rounding.sv
`default_nettype none
// ============================================================================
//  Module   : stochastic_rounding
//  Purpose  : Registered stochastic rounder for signed fixed-point samples.
//             Drops DROP_BITS LSBs, rounding up with probability equal to the
//             dropped fraction, using a 16-bit Fibonacci LFSR as the random
//             source. The result keeps the input format with the low bits
//             zeroed and saturates on positive overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module stochastic_rounding #(
    parameter int                    WIDTH      = 10,
    parameter int                    DROP_BITS  = 8,
    parameter int                    LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] SEED       = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  seed_load,
    input  logic [LFSR_WIDTH-1:0] seed,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data
);

    // Width of the integer part kept after the fractional bits are dropped.
    localparam int c_BW = WIDTH - DROP_BITS;

    // Largest positive value representable in the kept integer field.
    localparam logic [c_BW-1:0] c_SAT_MAX = {1'b0, {(c_BW-1){1'b1}}};

    logic [LFSR_WIDTH-1:0] r_lfsr;
    logic                  r_out_valid;
    logic [WIDTH-1:0]      r_out_data;

    logic                  w_fb;
    logic [DROP_BITS-1:0]  w_rand;
    logic [DROP_BITS-1:0]  w_frac;
    logic [c_BW-1:0]       w_base;
    logic                  w_inc;
    logic [c_BW:0]         w_sum;
    logic                  w_ovf;
    logic [c_BW-1:0]       w_sat;

    // Feedback taps are for the x^16+x^14+x^13+x^11+1 polynomial, so the
    // LFSR must be at least 16 bits wide.
    assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Rounding uses the LFSR state before this cycle's advance or seed load.
    assign w_rand = r_lfsr[DROP_BITS-1:0];
    assign w_frac = in_data[DROP_BITS-1:0];

    // Taking the upper bits is an arithmetic shift right (floor toward -inf).
    assign w_base = in_data[WIDTH-1:DROP_BITS];
    assign w_inc  = (w_rand < w_frac);

    // One extra bit so that base+1 at the top of the range is visible.
    assign w_sum  = {w_base[c_BW-1], w_base} + {{c_BW{1'b0}}, w_inc};

    // Adding 0 or 1 can only overflow upward: sign bit clear, next bit set.
    assign w_ovf  = ~w_sum[c_BW] & w_sum[c_BW-1];
    assign w_sat  = w_ovf ? c_SAT_MAX : w_sum[c_BW-1:0];

    // LFSR: reset to SEED, load on seed_load (zero maps to SEED), advance per sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (seed_load) begin
            r_lfsr <= (seed == '0) ? SEED : seed;
        end else if (in_valid) begin
            r_lfsr <= {r_lfsr[LFSR_WIDTH-2:0], w_fb};
        end
    end

    // Output register: valid follows in_valid, data updates only on accepted samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out_data <= {w_sat, {DROP_BITS{1'b0}}};
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_stochastic_rounding.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stochastic_rounding
//  Purpose  : Self-checking bench for stochastic_rounding with a behavioural
//             integer-arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stochastic_rounding;

    localparam int          c_WIDTH = 10;
    localparam int          c_DROP  = 8;
    localparam int          c_LW    = 16;
    localparam logic [15:0] c_SEED  = 16'hACE1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic [c_WIDTH-1:0]   in_data;
    logic                 seed_load;
    logic [c_LW-1:0]      seed;
    logic                 out_valid;
    logic [c_WIDTH-1:0]   out_data;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0]          m_lfsr;
    logic                 m_valid;
    logic [c_WIDTH-1:0]   m_data;

    stochastic_rounding #(
        .WIDTH      (c_WIDTH),
        .DROP_BITS  (c_DROP),
        .LFSR_WIDTH (c_LW),
        .SEED       (c_SEED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .seed_load (seed_load),
        .seed      (seed),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Rounding rule in plain integer arithmetic on the real value v/256.
    function automatic logic [c_WIDTH-1:0] round_ref(input int v, input logic [15:0] s);
        int frac;
        int base;
        int r;
        int res;
        frac = v & 255;
        base = (v - frac) / 256;
        r    = int'(s[7:0]);
        res  = base + ((r < frac) ? 1 : 0);
        if (res > 1) res = 1;
        return c_WIDTH'(res * 256);
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic cycle();
        if (!rst_n) begin
            m_lfsr  = c_SEED;
            m_valid = 1'b0;
            m_data  = '0;
        end else begin
            m_valid = in_valid;
            if (in_valid) m_data = round_ref(int'($signed(in_data)), m_lfsr);
            if (seed_load)     m_lfsr = (seed == 16'h0) ? c_SEED : seed;
            else if (in_valid) m_lfsr = lfsr_step(m_lfsr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b1; in_valid = 1'b0; in_data = '0; seed_load = 1'b0; seed = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        in_valid = 1'b1; seed_load = 1'b1; seed = 16'h5555; in_data = 10'sd100;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1; in_valid = 1'b0; seed_load = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 10'd0) begin
            errors++;
            $display("FAIL reset: out_valid=%b out_data=%0d, expected 0/0", out_valid, $signed(out_data));
        end
    endtask

    task automatic test_exact();
        int vals[4] = '{0, 256, -256, -512};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = c_WIDTH'(vals[i]);
            cycle();
            checks++;
            if (out_valid !== 1'b1 || out_data !== c_WIDTH'(vals[i])) begin
                errors++;
                $display("FAIL exact[%0d]: out_valid=%b out_data=%0d, expected 1/%0d",
                         i, out_valid, $signed(out_data), vals[i]);
            end
        end
        idle();
    endtask

    task automatic test_saturation();
        int bad = 0;
        for (int i = 0; i < 1000; i++) begin
            in_valid = 1'b1;
            in_data  = ($urandom_range(0, 1) == 0) ? 10'sd500 : 10'sd511;
            cycle();
            if (out_valid !== 1'b1 || out_data !== 10'd256) bad++;
        end
        idle();
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL saturation: %0d samples not 256, expected 0", bad);
        end
    endtask

    task automatic test_full_period();
        int highs = 0;
        int bad   = 0;
        int mism  = 0;
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            in_valid = 1'b1;
            in_data  = 10'sd100;
            cycle();
            if (out_data === 10'd256) highs++;
            else if (out_data !== 10'd0) bad++;
            if (out_valid !== m_valid || out_data !== m_data) mism++;
        end
        idle();
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL period_set: %0d outputs outside {0,256}, expected 0", bad);
        end
        checks++;
        if (highs != 25599) begin
            errors++;
            $display("FAIL period_count: %0d outputs equal 256, expected 25599", highs);
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL period_model: %0d samples differ from model, expected 0", mism);
        end
    endtask

    task automatic test_negative(input int v, input int n);
        int lo;
        int highs   = 0;
        int m_highs = 0;
        int bad     = 0;
        int mism    = 0;
        lo = ((v - (v & 255)) / 256) * 256;
        do_reset();
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = c_WIDTH'(v);
            cycle();
            if (m_data == c_WIDTH'(lo + 256)) m_highs++;
            if (out_data === c_WIDTH'(lo + 256)) highs++;
            else if (out_data !== c_WIDTH'(lo)) bad++;
            if (out_valid !== m_valid || out_data !== m_data) mism++;
        end
        idle();
        checks++;
        if (bad != 0 || highs != m_highs) begin
            errors++;
            $display("FAIL negative(%0d): out-of-set=%0d highs=%0d, expected 0 and %0d",
                     v, bad, highs, m_highs);
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL negative_model(%0d): %0d mismatches, expected 0", v, mism);
        end
    endtask

    task automatic test_gaps();
        logic [c_WIDTH-1:0] held;
        int mism = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = c_WIDTH'($urandom); cycle();
        end
        held = m_data;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b0; in_data = c_WIDTH'($urandom); cycle();
            checks++;
            if (out_valid !== 1'b0 || out_data !== held) begin
                errors++;
                $display("FAIL gap[%0d]: out_valid=%b out_data=%0d, expected 0/%0d",
                         i, out_valid, $signed(out_data), $signed(held));
            end
        end
        // The LFSR must have held: following samples still track the model.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = c_WIDTH'($urandom_range(1, 255)); cycle();
            if (out_valid !== 1'b1 || out_data !== m_data) mism++;
        end
        idle();
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL gap_resume: %0d mismatches after gap, expected 0", mism);
        end
    endtask

    // Load a seed, then send one sample and compare with a fixed expectation.
    task automatic seed_probe(input logic [15:0] sv, input int v, input int exp_v, input string nm);
        idle();
        seed_load = 1'b1; seed = sv;
        cycle();
        seed_load = 1'b0;
        in_valid = 1'b1; in_data = c_WIDTH'(v);
        cycle();
        idle();
        checks++;
        if (out_data !== c_WIDTH'(exp_v)) begin
            errors++;
            $display("FAIL %s: out_data=%0d, expected %0d", nm, $signed(out_data), exp_v);
        end
    endtask

    task automatic test_seed();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = c_WIDTH'($urandom); cycle();
        end
        // Zero seed falls back to 16'hACE1, so r = 8'hE1 = 225.
        seed_probe(16'h0000, 226, 256, "seed0_up");
        seed_probe(16'h0000, 225,   0, "seed0_down");
        // Seed 16'h1234 gives r = 8'h34 = 52.
        seed_probe(16'h1234,  53, 256, "seed1234_up");
        seed_probe(16'h1234,  52,   0, "seed1234_down");
        // Sample in the load cycle uses the pre-load state (ACE1 after reset).
        do_reset();
        in_valid = 1'b1; in_data = 10'sd226; seed_load = 1'b1; seed = 16'h1234;
        cycle();
        idle();
        checks++;
        if (out_data !== 10'd256) begin
            errors++;
            $display("FAIL seed_same_cycle: out_data=%0d, expected 256", $signed(out_data));
        end
        seed_probe(16'h1234, 52, 0, "seed_same_cycle_loaded");
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = c_WIDTH'($urandom);
            seed_load = ($urandom_range(0, 15) == 0);
            seed      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            cycle();
            checks++;
            if (out_valid !== m_valid || out_data !== m_data) begin
                errors++;
                $display("FAIL random[%0d]: valid=%b data=%0d, expected %b/%0d",
                         i, out_valid, $signed(out_data), m_valid, $signed(m_data));
            end
        end
        idle();
    endtask

    task automatic test_reset_replay();
        logic [c_WIDTH-1:0] a[20];
        logic [c_WIDTH-1:0] b[20];
        int mism = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = 10'sd255; cycle(); a[i] = out_data;
            if (out_data !== m_data) mism++;
        end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 10'd0) begin
            errors++;
            $display("FAIL midreset: out_valid=%b out_data=%0d, expected 0/0", out_valid, $signed(out_data));
        end
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = 10'sd255; cycle(); b[i] = out_data;
            if (a[i] !== b[i]) mism++;
        end
        idle();
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL replay: %0d differing samples, expected 0", mism);
        end
    endtask

    initial begin
        idle();
        m_lfsr = c_SEED; m_valid = 1'b0; m_data = '0;
        test_reset();
        test_exact();
        test_saturation();
        test_full_period();
        test_negative(-255, 4096);
        test_negative(-500, 4096);
        test_gaps();
        test_seed();
        test_random();
        test_reset_replay();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stochastic_rounding.md
Name: stochastic_rounding

Overview:
- Registered stochastic rounder for signed fixed-point samples.
- Drops the DROP_BITS fractional LSBs of a WIDTH-bit two's-complement input. It rounds up with probability equal to the dropped fraction, using an internal LFSR as the random source.
- The result is returned in the same WIDTH-bit format with the dropped bits zeroed.
- Used ahead of reduced-precision neural-network datapaths so quantisation error is unbiased in expectation.

Parameters:
- WIDTH, 10, data width of input and output (signed two's complement).
- DROP_BITS, 8, number of LSBs rounded away (default format Q2.8; 256 = 1.0).
- LFSR_WIDTH, 16, width of the random-source LFSR; must be >= DROP_BITS.
- SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_data holds a sample this cycle.
- in_data  input  WIDTH  signed input sample.
- seed_load  input  1  load seed into the LFSR this cycle.
- seed  input  LFSR_WIDTH  new LFSR value, used when seed_load=1.
- out_valid  output  1  out_data holds a new rounded sample.
- out_data  output  WIDTH  signed rounded sample, low DROP_BITS always 0.

Behaviour:
- Reset: one clock with rst_n=0 sets out_valid=0, out_data=0, LFSR=SEED. Reset overrides in_valid and seed_load.
- LFSR, Fibonacci, maximal length, taps x^16+x^14+x^13+x^11+1:
  - fb = s[15]^s[13]^s[12]^s[10]; next state = {s[14:0], fb}.
  - Advances exactly once per cycle with in_valid=1; holds otherwise.
  - seed_load=1 loads seed instead of advancing; if seed==0, SEED is loaded.
  - The sample accepted in the same cycle as seed_load uses the pre-load state.
- Rounding, per accepted sample, using the current (pre-advance) LFSR state s:
  - r = s[DROP_BITS-1:0], unsigned.
  - frac = in_data[DROP_BITS-1:0], unsigned.
  - base = in_data >>> DROP_BITS, arithmetic shift (floor toward -inf).
  - inc = (r < frac). frac=0 never rounds up, so exact values pass unchanged.
  - sum = base + inc, computed one bit wider than base.
  - Saturate sum to the signed range of WIDTH-DROP_BITS bits: default [-2, 1]. Only positive overflow is possible.
  - out_data = sat_sum << DROP_BITS.
- Latency 1 cycle: out_valid <= in_valid every cycle; out_data updates only when in_valid=1, otherwise holds its last value.
- Expected value equals in_data for all non-saturating inputs. Default maximum output is 256; minimum is -512.
- Reset mid-stream: the output pipeline clears and the LFSR returns to SEED, so replaying the same stimulus reproduces identical outputs.

Test Plan:
- Reset, then in_data=0, 256, -256, -512, one per cycle with in_valid=1 -> out_data=0, 256, -256, -512 exactly, each one cycle later, out_valid=1.
- in_data=500 (and 511) for 1000 cycles -> out_data=256 every sample (saturation, both rounding outcomes).
- After reset, in_data=100 for 65535 consecutive valid cycles -> every out in {0,256}; exactly 25599 results equal 256 (frac*256-1 over a full LFSR period).
- After reset, in_data=-255 for 65535 cycles -> outputs in {-256,0}; exactly 255 equal 0. in_data=-500 for 65535 cycles -> outputs in {-512,-256}; exactly 3071 equal -256.
- Gaps and seeding: with in_valid low for 10 cycles -> out_valid=0, out_data and LFSR unchanged. seed_load with seed=0 -> LFSR=16'hACE1. seed_load with seed=16'h1234 -> next sample uses r=8'h34.
- Reset mid-operation: assert rst_n=0 for one cycle during a stream of in_data=255 -> next cycle out_valid=0, out_data=0. Replaying the stream gives a bit-identical output sequence.
